// File: rtl/ps_setpoint_serializer_pkg.sv
// Shared widths and FSM encoding for the FOFB power-supply setpoint link.
// PS_DATA_W  : width of one PS setpoint code
// PS_CH_W    : width of the destination channel address
// PS_FRAME_W : serial frame length, {ch, data}
package fofb_ps_pkg;

    localparam int PS_DATA_W  = 20;
    localparam int PS_CH_W    = 4;
    localparam int PS_FRAME_W = PS_CH_W + PS_DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } ps_state_t;

endpackage

// File: rtl/ps_setpoint_serializer_sclk_tick.sv
// Serial clock divider for the PS DAC link.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   enable     : count while high
//   clear      : force the divider and sclk phase back to their start point
//   rise, fall : one-cycle strobes marking the sclk 0->1 and 1->0 toggles,
//                spaced CLK_DIV clk cycles apart
module ps_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          phase;
    logic          tick;

    always_comb begin
        tick = enable && (div_cnt == TERM);
        rise = tick && !phase;
        fall = tick && phase;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (enable) begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps_setpoint_serializer.sv
// Serialises tagged PS setpoints onto the PS DAC link.
// Each accepted {ch, data} word becomes a 24-bit MSB-first frame framed by
// csn, followed by an ldac_n load strobe and a short csn-high gap.
// One holding register accepts the next word while a frame is in flight.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   ps_in_data/ch     : setpoint and channel address, taken on valid & ready
//   ps_in_valid/ready : input handshake; ready means the holding register is empty
//   sclk, sdo, csn    : serial link (sclk idles low, sdo changes on sclk fall)
//   ldac_n            : DAC load strobe, low for LATCH_CYC cycles after a frame
//   busy              : a frame is being shifted, latched or gapped
//   frame_done        : one-cycle pulse on the first idle cycle after a frame
module ps_setpoint_serializer
    import fofb_ps_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int LATCH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PS_DATA_W-1:0] ps_in_data,
    input  logic [PS_CH_W-1:0]   ps_in_ch,
    input  logic                 ps_in_valid,
    output logic                 ps_in_ready,
    output logic                 sclk,
    output logic                 sdo,
    output logic                 csn,
    output logic                 ldac_n,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BIT_W = $clog2(PS_FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PS_FRAME_W - 1);
    localparam logic [15:0] LAT_TERM = 16'(LATCH_CYC - 1);
    localparam logic [15:0] GAP_TERM = 16'(CLK_DIV - 1);

    ps_state_t state, state_nxt;

    logic                  hold_valid;
    logic [PS_FRAME_W-1:0] hold_word;
    // Only the bits still to be sent; the bit on sdo is not kept here.
    logic [PS_FRAME_W-2:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [15:0]           cyc_cnt;

    logic rise, fall;
    logic load, tick_en, tick_clr;
    logic last_fall, latch_end, gap_end;

    ps_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .rise   (rise),
        .fall   (fall)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (hold_valid) state_nxt = SHIFT;
            SHIFT: if (last_fall)  state_nxt = LATCH;
            LATCH: if (latch_end)  state_nxt = GAP;
            GAP:   if (gap_end)    state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // State-decoded controls and status
    always_comb begin
        ps_in_ready = ~hold_valid;
        busy        = (state != IDLE);
        load        = (state == IDLE) && hold_valid;
        tick_en     = (state == SHIFT);
        tick_clr    = (state != SHIFT);
        last_fall   = fall && (bit_cnt == LAST_BIT);
        latch_end   = (state == LATCH) && (cyc_cnt == LAT_TERM);
        gap_end     = (state == GAP) && (cyc_cnt == GAP_TERM);
    end

    // Holding register, shifter and registered link outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            sclk       <= 1'b0;
            sdo        <= 1'b0;
            csn        <= 1'b1;
            ldac_n     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= gap_end;

            if (load) hold_valid <= 1'b0;
            if (ps_in_valid && !hold_valid) begin
                hold_word  <= {ps_in_ch, ps_in_data};
                hold_valid <= 1'b1;
            end

            if (load) begin
                shreg   <= hold_word[PS_FRAME_W-2:0];
                sdo     <= hold_word[PS_FRAME_W-1];
                csn     <= 1'b0;
                sclk    <= 1'b0;
                bit_cnt <= '0;
            end

            if (rise) sclk <= 1'b1;

            if (fall) begin
                sclk <= 1'b0;
                if (bit_cnt == LAST_BIT) begin
                    csn    <= 1'b1;
                    ldac_n <= 1'b0;
                    sdo    <= 1'b0;
                end else begin
                    sdo     <= shreg[PS_FRAME_W-2];
                    shreg   <= {shreg[PS_FRAME_W-3:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (latch_end) ldac_n <= 1'b1;

            // One counter times both LATCH and GAP; it restarts on every state change.
            if (state_nxt != state)
                cyc_cnt <= '0;
            else if (state == LATCH || state == GAP)
                cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps_setpoint_serializer.sv
// Self-checking bench for ps_setpoint_serializer.
// Instance 0 uses the default build (CLK_DIV=4, LATCH_CYC=2); instance 1 is
// the fast build (CLK_DIV=1, LATCH_CYC=1). Accepted words are pushed to a
// scoreboard queue and compared against the frames reassembled from sdo.
module tb_ps_setpoint_serializer;

    localparam int CD0 = 4;
    localparam int LC0 = 2;
    localparam int CD1 = 1;
    localparam int LC1 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [19:0] in_data [2];
    logic [3:0]  in_ch   [2];
    logic [1:0]  in_valid;
    logic [1:0]  ready_w, sclk_w, sdo_w, csn_w, ldac_w, busy_w, fd_w;

    ps_setpoint_serializer #(
        .CLK_DIV   (CD0),
        .LATCH_CYC (LC0)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ps_in_data  (in_data[0]),
        .ps_in_ch    (in_ch[0]),
        .ps_in_valid (in_valid[0]),
        .ps_in_ready (ready_w[0]),
        .sclk        (sclk_w[0]),
        .sdo         (sdo_w[0]),
        .csn         (csn_w[0]),
        .ldac_n      (ldac_w[0]),
        .busy        (busy_w[0]),
        .frame_done  (fd_w[0])
    );

    ps_setpoint_serializer #(
        .CLK_DIV   (CD1),
        .LATCH_CYC (LC1)
    ) u_fast (
        .clk         (clk),
        .reset       (reset),
        .ps_in_data  (in_data[1]),
        .ps_in_ch    (in_ch[1]),
        .ps_in_valid (in_valid[1]),
        .ps_in_ready (ready_w[1]),
        .sclk        (sclk_w[1]),
        .sdo         (sdo_w[1]),
        .csn         (csn_w[1]),
        .ldac_n      (ldac_w[1]),
        .busy        (busy_w[1]),
        .frame_done  (fd_w[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle-time %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int cd_of(input int k);
        return (k == 0) ? CD0 : CD1;
    endfunction

    function automatic int lc_of(input int k);
        return (k == 0) ? LC0 : LC1;
    endfunction

    logic [23:0] exp_q[$];

    // Monitor state, per instance
    int          cyc = 0;
    int          bits        [2] = '{0, 0};
    int          falls       [2] = '{0, 0};
    int          last_rise   [2] = '{0, 0};
    int          fall_cyc    [2] = '{0, 0};
    int          fall_gap    [2] = '{0, 0};
    int          starts      [2] = '{0, 0};
    int          ldac_run    [2] = '{0, 0};
    int          ldac_pulses [2] = '{0, 0};
    int          fd_cnt      [2] = '{0, 0};
    int          last_fd     [2] = '{0, 0};
    logic [23:0] sh          [2];
    logic [1:0]  p_csn   = 2'b11;
    logic [1:0]  p_sclk  = 2'b00;
    logic [1:0]  p_ldac  = 2'b11;
    logic [1:0]  p_ready = 2'b11;
    logic        p_reset = 1'b1;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                bits[k]     = 0;
                falls[k]    = 0;
                ldac_run[k] = 0;
            end else begin
                if (!csn_w[k] && p_csn[k]) begin
                    starts[k]++;
                    fall_gap[k] = cyc - last_fd[k];
                    fall_cyc[k] = cyc;
                    bits[k]     = 0;
                    falls[k]    = 0;
                    sh[k]       = '0;
                end
                if (sclk_w[k] && !p_sclk[k]) begin
                    if (bits[k] > 0)
                        chk($sformatf("sclk_period%0d", k), 32'(cyc - last_rise[k]), 32'(2 * cd_of(k)));
                    last_rise[k] = cyc;
                    sh[k] = {sh[k][22:0], sdo_w[k]};
                    bits[k]++;
                end
                if (!sclk_w[k] && p_sclk[k]) falls[k]++;
                if (csn_w[k] && !p_csn[k] && !p_reset) begin
                    chk($sformatf("csn_low_len%0d", k), 32'(cyc - fall_cyc[k]), 32'(48 * cd_of(k)));
                    chk($sformatf("sclk_rises%0d", k), 32'(bits[k]), 32'd24);
                    chk($sformatf("ldac_start%0d", k), 32'(ldac_w[k]), 32'd0);
                    chk($sformatf("frame_expected%0d", k), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0)
                        chk($sformatf("frame_data%0d", k), 32'(sh[k]), 32'(exp_q.pop_front()));
                end
                if (!ldac_w[k]) begin
                    ldac_run[k]++;
                end else if (!p_ldac[k]) begin
                    chk($sformatf("ldac_len%0d", k), 32'(ldac_run[k]), 32'(lc_of(k)));
                    ldac_pulses[k]++;
                    ldac_run[k] = 0;
                end
                if (fd_w[k]) begin
                    chk($sformatf("frame_period%0d", k), 32'(cyc - fall_cyc[k]),
                        32'(49 * cd_of(k) + lc_of(k)));
                    fd_cnt[k]++;
                    last_fd[k] = cyc;
                end
                // hold only empties by moving into the shifter, which starts a frame
                if (ready_w[k] && !p_ready[k] && !p_reset)
                    chk($sformatf("ready_on_load%0d", k), 32'({csn_w[k], p_csn[k]}), 32'b01);
            end
        end
        p_csn   = csn_w;
        p_sclk  = sclk_w;
        p_ldac  = ldac_w;
        p_ready = ready_w;
        p_reset = reset;
    end

    // Offer one word; returns just after the accepting edge.
    task automatic send(input int k, input logic [3:0] ch, input logic [19:0] d, input bit keep);
        int t = 0;
        @(negedge clk);
        in_ch[k]    = ch;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        while (!ready_w[k] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("accept_timeout%0d", k), 32'(t < 1000), 32'd1);
        @(posedge clk);
        exp_q.push_back({ch, d});
        #1;
        if (!keep) in_valid[k] = 1'b0;
    endtask

    task automatic wait_fd(input int k, input int n);
        int t = 0;
        while (fd_cnt[k] < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frame_done_wait%0d", k), 32'(fd_cnt[k] >= n), 32'd1);
    endtask

    int base_pulses;
    int base_fd;
    int base_starts;
    int t;

    initial begin
        in_valid = '0;
        for (int k = 0; k < 2; k++) begin
            in_data[k] = '0;
            in_ch[k]   = '0;
        end

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(ready_w[k]), 32'd1);
            chk($sformatf("rst_sclk%0d", k),  32'(sclk_w[k]),  32'd0);
            chk($sformatf("rst_sdo%0d", k),   32'(sdo_w[k]),   32'd0);
            chk($sformatf("rst_csn%0d", k),   32'(csn_w[k]),   32'd1);
            chk($sformatf("rst_ldac%0d", k),  32'(ldac_w[k]),  32'd1);
            chk($sformatf("rst_busy%0d", k),  32'(busy_w[k]),  32'd0);
            chk($sformatf("rst_fd%0d", k),    32'(fd_w[k]),    32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: single word
        send(0, 4'h3, 20'hA5A5A, 1'b0);
        wait_fd(0, 1);

        // 2: back-to-back
        base_pulses = ldac_pulses[0];
        send(0, 4'h1, 20'h12345, 1'b0);
        send(0, 4'h2, 20'h6789A, 1'b0);
        @(negedge clk);
        chk("ready_after_2nd", 32'(ready_w[0]), 32'd0);
        wait_fd(0, 3);
        chk("b2b_csn_after_fd", 32'(fall_gap[0]), 32'd1);
        chk("b2b_ldac_pulses", 32'(ldac_pulses[0] - base_pulses), 32'd2);

        // 3: backpressure, valid held high across three words
        send(0, 4'h5, 20'h0F0F0, 1'b1);
        send(0, 4'hA, 20'hCAFE1, 1'b1);
        send(0, 4'hC, 20'h13579, 1'b0);
        wait_fd(0, 6);

        // 4: reset at bit_cnt=10 with a second word waiting in hold
        base_fd     = fd_cnt[0];
        base_starts = starts[0];
        send(0, 4'h7, 20'h11111, 1'b0);
        send(0, 4'h8, 20'h22222, 1'b0);
        t = 0;
        while (!(starts[0] > base_starts && falls[0] >= 10) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_bit10", 32'(t < 1000), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_csn",   32'(csn_w[0]),   32'd1);
        chk("midrst_sclk",  32'(sclk_w[0]),  32'd0);
        chk("midrst_ldac",  32'(ldac_w[0]),  32'd1);
        chk("midrst_ready", 32'(ready_w[0]), 32'd1);
        chk("midrst_busy",  32'(busy_w[0]),  32'd0);
        exp_q.delete();
        base_starts = starts[0];
        repeat (300) @(negedge clk);
        chk("midrst_no_frame", 32'(starts[0] - base_starts), 32'd0);
        chk("midrst_no_fd",    32'(fd_cnt[0] - base_fd),     32'd0);
        chk("midrst_idle_csn", 32'(csn_w[0]),                32'd1);

        // 5: extremes
        base_fd = fd_cnt[0];
        send(0, 4'hF, 20'hFFFFF, 1'b0);
        send(0, 4'h0, 20'h00000, 1'b0);
        wait_fd(0, base_fd + 2);

        // 6: fast build
        send(1, 4'h3, 20'hA5A5A, 1'b0);
        wait_fd(1, 1);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
